// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable limit, step, parallel load and
// wrap/saturate boundary handling; reports a terminal-count pulse and sticky flags.
module updown_counter_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic             sat_mode,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow,
    output logic             underflow,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] min_w(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             overflow_r;
    logic             underflow_r;

    logic [WIDTH:0]   ext_cnt_s;
    logic [WIDTH:0]   ext_lim_s;
    logic [WIDTH:0]   es_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] wrap_up_s;
    logic [WIDTH-1:0] wrap_dn_s;
    logic [WIDTH-1:0] next_count_s;
    logic             up_evt_s;
    logic             dn_evt_s;

    // Extended-width operands so the sum and wrap terms never truncate silently.
    always_comb begin
        ext_cnt_s = {1'b0, count_r};
        ext_lim_s = {1'b0, limit};
        es_s      = {1'b0, min_w(step, limit)};
        sum_s     = ext_cnt_s + es_s;
        diff_s    = WIDTH'(ext_cnt_s - es_s);
        wrap_up_s = WIDTH'(sum_s - ext_lim_s - ONE_EXT);
        // Rearranged so the intermediate never goes negative when count < es.
        wrap_dn_s = WIDTH'(ext_lim_s - (es_s - ext_cnt_s) + ONE_EXT);
    end

    // Next count and boundary events; load takes precedence over enable.
    always_comb begin
        next_count_s = count_r;
        up_evt_s     = 1'b0;
        dn_evt_s     = 1'b0;
        if (load) begin
            next_count_s = min_w(load_value, limit);
        end else if (enable) begin
            if (es_s == {(WIDTH+1){1'b0}}) begin
                next_count_s = count_r;
            end else if (ext_cnt_s > ext_lim_s) begin
                // Limit was lowered under the current count: pull back into range.
                up_evt_s = up_down;
                dn_evt_s = ~up_down;
                if (sat_mode || !up_down) begin
                    next_count_s = limit;
                end else begin
                    next_count_s = {WIDTH{1'b0}};
                end
            end else if (up_down) begin
                if (sum_s <= ext_lim_s) begin
                    next_count_s = sum_s[WIDTH-1:0];
                end else begin
                    up_evt_s     = 1'b1;
                    next_count_s = sat_mode ? limit : wrap_up_s;
                end
            end else begin
                if (ext_cnt_s >= es_s) begin
                    next_count_s = diff_s;
                end else begin
                    dn_evt_s     = 1'b1;
                    next_count_s = sat_mode ? {WIDTH{1'b0}} : wrap_dn_s;
                end
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // State register; a flag set in the same cycle as clear_flags stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r     <= up_down ? {WIDTH{1'b0}} : limit;
            tc_r        <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= next_count_s;
            tc_r        <= up_evt_s | dn_evt_s;
            overflow_r  <= up_evt_s | (overflow_r & ~clear_flags);
            underflow_r <= dn_evt_s | (underflow_r & ~clear_flags);
        end
    end

    assign count     = count_r;
    assign tc        = tc_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign at_max    = (count_r == limit);
    assign at_zero   = (count_r == {WIDTH{1'b0}});

endmodule
